receiver_burst_scheduler: RTL

Sequences the receiver sample stream into a programmable burst of packets per master trigger. Sits between the ADC sample output (already in the DSP clock domain) and the packet consumer, such as the debug streamer or DSP chain. Replaces the fixed single-window "N samples per trigger" behaviour with a burst of packets of programmable length, gap and count. Detects and counts triggers that arrive while a burst is in progress.

---
 rtl/receiver_pkg.sv | 16 +
 rtl/receiver_burst_scheduler_if.sv | 32 +++
 rtl/receiver_burst_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/receiver_pkg.sv
// Shared types for the receiver burst scheduler: output packet beat and scheduler state.
package receiver_pkg;
  localparam int DEF_DATA_W  = 14;
  localparam int DEF_LEN_W   = 12;
  localparam int DEF_BURST_W = 8;
  localparam int DEF_OVR_W   = 16;

  typedef struct packed {
    logic                  SoP;
    logic                  EoP;
    logic [DEF_DATA_W-1:0] Data;
    logic                  Valid;
  } PACKET;

  typedef enum logic [1:0] {IDLE, SAMPLING, GAP} sched_state_e;
endpackage

// File: rtl/receiver_burst_scheduler_if.sv
// Sample-in / packet-out bus of the burst scheduler; master drives config and samples.
interface receiver_burst_scheduler_if
  import receiver_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int OVR_W   = DEF_OVR_W
);
  logic                  ipEnable;
  logic [LEN_W-1:0]      ipPacketLength;
  logic [LEN_W-1:0]      ipGapSamples;
  logic [BURST_W-1:0]    ipBurstCount;
  logic                  ipTrigger;
  logic [DEF_DATA_W-1:0] ipSampleData;
  logic                  ipSampleValid;
  PACKET                 opPacket;
  logic [BURST_W-1:0]    opPacketIndex;
  logic                  opBusy;
  logic                  opDone;
  logic [OVR_W-1:0]      opOverrunCount;

  modport master (
    output ipEnable, ipPacketLength, ipGapSamples, ipBurstCount, ipTrigger,
           ipSampleData, ipSampleValid,
    input  opPacket, opPacketIndex, opBusy, opDone, opOverrunCount
  );
  modport slave (
    input  ipEnable, ipPacketLength, ipGapSamples, ipBurstCount, ipTrigger,
           ipSampleData, ipSampleValid,
    output opPacket, opPacketIndex, opBusy, opDone, opOverrunCount
  );
endinterface

// File: rtl/receiver_burst_scheduler.sv
// Cuts the ADC sample stream into a burst of fixed-length packets with gaps per trigger,
// counting triggers that land while a burst is still running.
module receiver_burst_scheduler
  import receiver_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int OVR_W   = DEF_OVR_W
) (
  input logic ipClk,
  input logic ipReset,
  receiver_burst_scheduler_if.slave bus
);
  sched_state_e       state_q, state_d;
  logic [LEN_W-1:0]   n_q, n_d, g_q, g_d, len_q, len_d, gap_q, gap_d;
  logic [BURST_W-1:0] k_q, k_d, cnt_q, cnt_d, idx_q, idx_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;
  PACKET              pkt_q, pkt_d;
  logic               done_q, done_d;
  logic               accept, last_beat;

  assign accept    = bus.ipTrigger && bus.ipEnable &&
                     (bus.ipPacketLength != '0) && (bus.ipBurstCount != '0);
  assign last_beat = (n_q == len_q - LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    g_d       = g_q;
    k_d       = k_q;
    len_d     = len_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pkt_d     = pkt_q;
    pkt_d.Valid = 1'b0;
    done_d    = 1'b0;
    ovr_d     = ovr_q;

    // Any trigger outside Idle is dropped, including one on the final sample.
    if (bus.ipTrigger && (state_q != IDLE) && (ovr_q != '1))
      ovr_d = ovr_q + OVR_W'(1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SAMPLING;
          n_d     = '0;
          g_d     = '0;
          k_d     = '0;
          len_d   = bus.ipPacketLength;
          gap_d   = bus.ipGapSamples;
          cnt_d   = bus.ipBurstCount;
        end
      end
      SAMPLING: begin
        if (bus.ipSampleValid) begin
          pkt_d.Valid = 1'b1;
          pkt_d.Data  = bus.ipSampleData;
          pkt_d.SoP   = (n_q == '0);
          pkt_d.EoP   = last_beat;
          idx_d       = k_q;
          n_d         = n_q + LEN_W'(1);
          if (last_beat) begin
            n_d = '0;
            if (k_q == cnt_q - BURST_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (!bus.ipEnable) begin
              state_d = IDLE;
            end else if (gap_q == '0) begin
              k_d = k_q + BURST_W'(1);
            end else begin
              state_d = GAP;
              g_d     = '0;
            end
          end
        end
      end
      GAP: begin
        if (!bus.ipEnable) begin
          state_d = IDLE;
        end else if (bus.ipSampleValid) begin
          g_d = g_q + LEN_W'(1);
          if (g_q == gap_q - LEN_W'(1)) begin
            state_d = SAMPLING;
            g_d     = '0;
            k_d     = k_q + BURST_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q <= IDLE;
      n_q     <= '0;
      g_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pkt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      g_q     <= g_d;
      k_q     <= k_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Busy tracks the state register so it drops with the final EoP beat.
  assign bus.opBusy         = (state_q != IDLE);
  assign bus.opPacket       = pkt_q;
  assign bus.opPacketIndex  = idx_q;
  assign bus.opDone         = done_q;
  assign bus.opOverrunCount = ovr_q;
endmodule
